// File: rtl/dmem_arbiter_if.sv
// One requester's command/response bundle for dmem_arbiter.
// The requester uses the master modport and the arbiter uses the slave modport.
interface dmem_arbiter_if #(
    parameter int DSIZE     = 16,
    parameter int MEM_SPACE = 8
);
    logic                 req;
    logic                 we;
    logic                 lock;
    logic [MEM_SPACE-1:0] addr;
    logic [DSIZE-1:0]     wdata;
    logic                 gnt;
    logic                 rvalid;
    logic [DSIZE-1:0]     rdata;

    modport master (output req, we, lock, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, lock, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port D_memory, with a bounded exclusive lock.
// Build option: define DMEM_ARB_RR_EN for round-robin conflict resolution (default: port A wins).
module dmem_arbiter #(
    parameter int LOCK_MAX  = 8,
    parameter int DSIZE     = 16,
    parameter int MEM_SPACE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    dmem_arbiter_if.slave        port_a,
    dmem_arbiter_if.slave        port_b,
    output logic [MEM_SPACE-1:0] mem_address,
    output logic [DSIZE-1:0]     mem_data_in,
    output logic                 mem_write_en,
    input  logic [DSIZE-1:0]     mem_data_out
);

`ifdef DMEM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif
    localparam logic [3:0] LOCK_MAX_C = 4'(LOCK_MAX);

    typedef enum logic [1:0] {OWN_NONE, OWN_A, OWN_B} own_t;

    own_t                 r_owner;
    logic                 r_last;        // 0 = A, 1 = B
    logic [3:0]           r_lock_cnt;
    logic [1:0]           r_rvalid;
    logic [MEM_SPACE-1:0] r_addr;
    logic [DSIZE-1:0]     r_wdata;

    logic [1:0]           w_req;
    logic [1:0]           w_we;
    logic [1:0]           w_lock;
    logic [1:0]           w_gnt;
    logic [MEM_SPACE-1:0] w_addr  [2];
    logic [DSIZE-1:0]     w_wdata [2];
    logic [DSIZE-1:0]     w_rdata [2];
    logic                 w_pick_b;

    assign w_req      = {port_b.req,  port_a.req};
    assign w_we       = {port_b.we,   port_a.we};
    assign w_lock     = {port_b.lock, port_a.lock};
    assign w_addr[0]  = port_a.addr;
    assign w_addr[1]  = port_b.addr;
    assign w_wdata[0] = port_a.wdata;
    assign w_wdata[1] = port_b.wdata;

    // On a conflict, B wins only in the round-robin build and only when A went last.
    assign w_pick_b = RR_EN && !r_last;

    always_comb begin
        w_gnt = 2'b00;
        if (!rst) begin
            case (r_owner)
                OWN_A:   w_gnt[0] = w_req[0];
                OWN_B:   w_gnt[1] = w_req[1];
                default: begin
                    if (w_req == 2'b11) begin
                        w_gnt = w_pick_b ? 2'b10 : 2'b01;
                    end else begin
                        w_gnt = w_req;
                    end
                end
            endcase
        end
    end

    // The memory samples its command at the edge that ends the grant cycle.
    always_comb begin
        mem_address  = r_addr;
        mem_data_in  = r_wdata;
        mem_write_en = 1'b1;
        if (w_gnt[0]) begin
            mem_address  = w_addr[0];
            mem_data_in  = w_wdata[0];
            mem_write_en = !w_we[0];
        end else if (w_gnt[1]) begin
            mem_address  = w_addr[1];
            mem_data_in  = w_wdata[1];
            mem_write_en = !w_we[1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner    <= OWN_NONE;
            r_last     <= 1'b1;
            r_lock_cnt <= 4'd0;
            r_rvalid   <= 2'b00;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else begin
            r_rvalid <= w_gnt & ~w_we;
            if (w_gnt[0]) begin
                r_last  <= 1'b0;
                r_addr  <= w_addr[0];
                r_wdata <= w_wdata[0];
            end else if (w_gnt[1]) begin
                r_last  <= 1'b1;
                r_addr  <= w_addr[1];
                r_wdata <= w_wdata[1];
            end
            case (r_owner)
                OWN_NONE: begin
                    if (w_gnt[0] && w_lock[0]) begin
                        r_owner    <= OWN_A;
                        r_lock_cnt <= 4'd1;
                    end else if (w_gnt[1] && w_lock[1]) begin
                        r_owner    <= OWN_B;
                        r_lock_cnt <= 4'd1;
                    end
                end
                OWN_A: begin
                    if (!w_lock[0] || r_lock_cnt >= LOCK_MAX_C) begin
                        r_owner    <= OWN_NONE;
                        r_lock_cnt <= 4'd0;
                    end else begin
                        r_lock_cnt <= r_lock_cnt + 4'd1;
                    end
                end
                OWN_B: begin
                    if (!w_lock[1] || r_lock_cnt >= LOCK_MAX_C) begin
                        r_owner    <= OWN_NONE;
                        r_lock_cnt <= 4'd0;
                    end else begin
                        r_lock_cnt <= r_lock_cnt + 4'd1;
                    end
                end
                default: begin
                    r_owner    <= OWN_NONE;
                    r_lock_cnt <= 4'd0;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ret
            assign w_rdata[gi] = r_rvalid[gi] ? mem_data_out : '0;
        end
    endgenerate

    assign port_a.gnt    = w_gnt[0];
    assign port_b.gnt    = w_gnt[1];
    assign port_a.rvalid = r_rvalid[0];
    assign port_b.rvalid = r_rvalid[1];
    assign port_a.rdata  = w_rdata[0];
    assign port_b.rdata  = w_rdata[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a synchronous single-port memory model.
// Expected values are hand-computed; conflict rows depend on DMEM_ARB_RR_EN.
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  mem_address;
    logic [15:0] mem_data_in;
    logic        mem_write_en;
    logic [15:0] mem_data_out;
    logic [15:0] mem [0:255];

    int n_total = 0;
    int n_pass  = 0;

    dmem_arbiter_if #(.DSIZE(16), .MEM_SPACE(8)) if_a ();
    dmem_arbiter_if #(.DSIZE(16), .MEM_SPACE(8)) if_b ();

    dmem_arbiter #(.LOCK_MAX(8), .DSIZE(16), .MEM_SPACE(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .port_a       (if_a),
        .port_b       (if_b),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_write_en (mem_write_en),
        .mem_data_out (mem_data_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!mem_write_en) mem[mem_address] <= mem_data_in;
        else               mem_data_out     <= mem[mem_address];
    end

    typedef struct {
        logic a_req, a_we, a_lock; logic [7:0] a_addr; logic [15:0] a_wdata;
        logic b_req, b_we, b_lock; logic [7:0] b_addr; logic [15:0] b_wdata;
        logic e_agnt, e_bgnt, e_arv, e_brv; logic [15:0] e_ard, e_brd;
        logic e_we; logic [7:0] e_addr; logic [15:0] e_din;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s [%0d]: got %h expected %h", nm, idx, act, exp);
        else n_pass++;
    endtask

    task automatic set_a(input logic req, input logic we, input logic lock, input logic [7:0] addr, input logic [15:0] wd);
        if_a.req = req; if_a.we = we; if_a.lock = lock; if_a.addr = addr; if_a.wdata = wd;
    endtask

    task automatic set_b(input logic req, input logic we, input logic lock, input logic [7:0] addr, input logic [15:0] wd);
        if_b.req = req; if_b.we = we; if_b.lock = lock; if_b.addr = addr; if_b.wdata = wd;
    endtask

    task automatic do_reset;
        set_a(0, 0, 0, 8'h00, 16'h0);
        set_b(0, 0, 0, 8'h00, 16'h0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h01] = 16'h1111; mem[8'h02] = 16'h2222; mem[8'h05] = 16'h1234;
        mem[8'h20] = 16'h00AA; mem[8'h30] = 16'h3333;
        mem_data_out = 16'h0;

        // a_req/we/lock,addr,wdata | b_req/we/lock,addr,wdata | agnt,bgnt,arv,brv,ard,brd | we,addr,din
`ifdef DMEM_ARB_RR_EN
        vecs[0]  = '{1,0,0,8'h01,16'h0, 1,0,0,8'h02,16'h0, 1,0,0,0,16'h0,   16'h0,    1,8'h01,16'h0};
        vecs[1]  = '{1,0,0,8'h01,16'h0, 1,0,0,8'h02,16'h0, 0,1,1,0,16'h1111,16'h0,    1,8'h02,16'h0};
        vecs[2]  = '{1,0,0,8'h01,16'h0, 1,0,0,8'h02,16'h0, 1,0,0,1,16'h0,   16'h2222, 1,8'h01,16'h0};
        vecs[3]  = '{1,0,0,8'h01,16'h0, 1,0,0,8'h02,16'h0, 0,1,1,0,16'h1111,16'h0,    1,8'h02,16'h0};
        vecs[4]  = '{0,0,0,8'h00,16'h0, 0,0,0,8'h00,16'h0, 0,0,0,1,16'h0,   16'h2222, 1,8'h02,16'h0};
`else
        vecs[0]  = '{1,0,0,8'h01,16'h0, 1,0,0,8'h02,16'h0, 1,0,0,0,16'h0,   16'h0,    1,8'h01,16'h0};
        vecs[1]  = '{1,0,0,8'h01,16'h0, 1,0,0,8'h02,16'h0, 1,0,1,0,16'h1111,16'h0,    1,8'h01,16'h0};
        vecs[2]  = '{1,0,0,8'h01,16'h0, 1,0,0,8'h02,16'h0, 1,0,1,0,16'h1111,16'h0,    1,8'h01,16'h0};
        vecs[3]  = '{1,0,0,8'h01,16'h0, 1,0,0,8'h02,16'h0, 1,0,1,0,16'h1111,16'h0,    1,8'h01,16'h0};
        vecs[4]  = '{0,0,0,8'h00,16'h0, 0,0,0,8'h00,16'h0, 0,0,1,0,16'h1111,16'h0,    1,8'h01,16'h0};
`endif
        vecs[5]  = '{1,0,0,8'h05,16'h0, 0,0,0,8'h00,16'h0, 1,0,0,0,16'h0,   16'h0,    1,8'h05,16'h0};
        vecs[6]  = '{0,0,0,8'h00,16'h0, 0,0,0,8'h00,16'h0, 0,0,1,0,16'h1234,16'h0,    1,8'h05,16'h0};
        vecs[7]  = '{0,0,0,8'h00,16'h0, 1,1,0,8'h10,16'hBEEF, 0,1,0,0,16'h0, 16'h0,   0,8'h10,16'hBEEF};
        vecs[8]  = '{0,0,0,8'h00,16'h0, 1,0,0,8'h10,16'h0, 0,1,0,0,16'h0,   16'h0,    1,8'h10,16'h0};
        vecs[9]  = '{0,0,0,8'h00,16'h0, 0,0,0,8'h00,16'h0, 0,0,0,1,16'h0,   16'hBEEF, 1,8'h10,16'h0};
        vecs[10] = '{1,0,1,8'h20,16'h0, 1,0,0,8'h30,16'h0, 1,0,0,0,16'h0,   16'h0,    1,8'h20,16'h0};
        vecs[11] = '{1,1,0,8'h20,16'h00AB, 1,0,0,8'h30,16'h0, 1,0,1,0,16'h00AA,16'h0, 0,8'h20,16'h00AB};
        vecs[12] = '{0,0,0,8'h00,16'h0, 1,0,0,8'h30,16'h0, 0,1,0,0,16'h0,   16'h0,    1,8'h30,16'h0};
        vecs[13] = '{1,0,0,8'h20,16'h0, 0,0,0,8'h00,16'h0, 1,0,0,1,16'h0,   16'h3333, 1,8'h20,16'h0};
        vecs[14] = '{0,0,0,8'h00,16'h0, 0,0,0,8'h00,16'h0, 0,0,1,0,16'h00AB,16'h0,    1,8'h20,16'h0};

        // Reset state, with A requesting a write to prove the grant is gated.
        set_a(1, 1, 0, 8'h07, 16'h5555);
        set_b(1, 0, 0, 8'h08, 16'h0);
        @(negedge clk);
        chk("rst_agnt", 0, 32'(if_a.gnt), 32'd0);
        chk("rst_bgnt", 0, 32'(if_b.gnt), 32'd0);
        chk("rst_arv",  0, 32'(if_a.rvalid), 32'd0);
        chk("rst_brv",  0, 32'(if_b.rvalid), 32'd0);
        chk("rst_ard",  0, 32'(if_a.rdata), 32'd0);
        chk("rst_we",   0, 32'(mem_write_en), 32'd1);
        chk("rst_addr", 0, 32'(mem_address), 32'd0);
        chk("rst_din",  0, 32'(mem_data_in), 32'd0);
        do_reset;

        for (int i = 0; i < 15; i++) begin
            set_a(vecs[i].a_req, vecs[i].a_we, vecs[i].a_lock, vecs[i].a_addr, vecs[i].a_wdata);
            set_b(vecs[i].b_req, vecs[i].b_we, vecs[i].b_lock, vecs[i].b_addr, vecs[i].b_wdata);
            @(negedge clk);
            $display("vec %0d: agnt=%0b bgnt=%0b arv=%0b brv=%0b ard=%h brd=%h we=%0b addr=%h din=%h",
                     i, if_a.gnt, if_b.gnt, if_a.rvalid, if_b.rvalid, if_a.rdata, if_b.rdata,
                     mem_write_en, mem_address, mem_data_in);
            chk("a_gnt",    i, 32'(if_a.gnt),    32'(vecs[i].e_agnt));
            chk("b_gnt",    i, 32'(if_b.gnt),    32'(vecs[i].e_bgnt));
            chk("a_rvalid", i, 32'(if_a.rvalid), 32'(vecs[i].e_arv));
            chk("b_rvalid", i, 32'(if_b.rvalid), 32'(vecs[i].e_brv));
            chk("a_rdata",  i, 32'(if_a.rdata),  32'(vecs[i].e_ard));
            chk("b_rdata",  i, 32'(if_b.rdata),  32'(vecs[i].e_brd));
            chk("mem_we",   i, 32'(mem_write_en), 32'(vecs[i].e_we));
            chk("mem_addr", i, 32'(mem_address),  32'(vecs[i].e_addr));
            chk("mem_din",  i, 32'(mem_data_in),  32'(vecs[i].e_din));
            @(posedge clk);
            #1;
        end

        // Forced release: A takes the lock, then idles with lock held; B waits 8 cycles.
        do_reset;
        set_a(1, 0, 1, 8'h05, 16'h0);
        set_b(1, 0, 0, 8'h02, 16'h0);
        @(negedge clk);
        chk("fr_agnt0", 0, 32'(if_a.gnt), 32'd1);
        chk("fr_bgnt0", 0, 32'(if_b.gnt), 32'd0);
        @(posedge clk);
        #1 if_a.req = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            $display("lock cycle %0d: agnt=%0b bgnt=%0b", k, if_a.gnt, if_b.gnt);
            chk("fr_bgnt_held", k, 32'(if_b.gnt), 32'd0);
            if (k == 1) chk("fr_ard", k, 32'(if_a.rdata), 32'h1234);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        $display("release cycle: agnt=%0b bgnt=%0b", if_a.gnt, if_b.gnt);
        chk("fr_bgnt_rel", 9, 32'(if_b.gnt), 32'd1);
        chk("fr_agnt_rel", 9, 32'(if_a.gnt), 32'd0);
        @(posedge clk);
        #1;

        // Reset in the cycle after a read grant, while A attempts a write.
        do_reset;
        set_a(1, 0, 0, 8'h05, 16'h0);
        set_b(0, 0, 0, 8'h00, 16'h0);
        @(negedge clk);
        chk("mr_agnt", 0, 32'(if_a.gnt), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        set_a(1, 1, 0, 8'h05, 16'hFFFF);
        #1;
        $display("mid-reset: arv=%0b agnt=%0b we=%0b addr=%h", if_a.rvalid, if_a.gnt, mem_write_en, mem_address);
        chk("mr_arv",  1, 32'(if_a.rvalid), 32'd0);
        chk("mr_agnt", 1, 32'(if_a.gnt), 32'd0);
        chk("mr_we",   1, 32'(mem_write_en), 32'd1);
        chk("mr_addr", 1, 32'(mem_address), 32'd0);
        @(posedge clk);
        #1;
        chk("mr_mem05", 2, 32'(mem[8'h05]), 32'h1234);
        rst = 1'b0;
        set_a(0, 0, 0, 8'h00, 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single-port `D_memory` data memory between the CPU MEM stage (port A) and a loader/DMA engine (port B). Each cycle it issues at most one access, drives the memory's address, write data and active-low write enable, and routes the one-cycle-latency read data back to the requester that issued the read. A lock mechanism with a bounded hold time lets one port perform atomic read-modify-write sequences.

## Interface
- `LOCK_MAX`, 8: max consecutive cycles one port may hold the lock (1..15).
- Widths `DSIZE` and `MEM_SPACE` come from `define.v`.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  **asynchronous reset, active-high**.
- `a_req`, `b_req`  in  1  access request; held with its command until granted.
- `a_we`, `b_we`  in  1  1 = write, 0 = read (active-high at this interface).
- `a_addr`, `b_addr`  in  `MEM_SPACE`  word address.
- `a_wdata`, `b_wdata`  in  `DSIZE`  write data.
- `a_lock`, `b_lock`  in  1  request/keep exclusive ownership.
- `a_gnt`, `b_gnt`  out  1  access issued at the next rising edge (combinational).
- `a_rvalid`, `b_rvalid`  out  1  read data valid this cycle (registered).
- `a_rdata`, `b_rdata`  out  `DSIZE`  read data, meaningful only while `*_rvalid` is high.
- `mem_address`  out  `MEM_SPACE`  to `D_memory.address`.
- `mem_data_in`  out  `DSIZE`  to `D_memory.data_in`.
- `mem_write_en`  out  1  to `D_memory.write_en`, active-low.
- `mem_data_out`  in  `DSIZE`  from `D_memory.data_out`.

## Operation
- Owner FSM states: `OWN_NONE`, `OWN_A`, `OWN_B`. Reset → `OWN_NONE`.
- `OWN_NONE`: grant one requester.
  - Only one port requests → grant it.
  - Both request → round-robin pointer `last` decides (see Configuration).
  - Granted with `*_lock`=1 → next state `OWN_x`, lock counter loads 1.
- `OWN_x`: only port x may be granted; the other port's `gnt` stays 0 even if it requests.
  - Leave to `OWN_NONE` when x samples `*_lock`=0 at an edge, or when the counter reaches `LOCK_MAX` (forced release; x must re-arbitrate).
  - Counter increments every cycle in `OWN_x`, whether or not x issues an access.
- Grant cycle: `mem_address`=granted addr, `mem_data_in`=granted wdata, `mem_write_en`=~granted we. No grant: `mem_write_en`=1, address/data hold last values.
- Read return: `*_rvalid` registered 1 for exactly the cycle after a granted read; `*_rdata` = `mem_data_out`. Writes produce no `rvalid`. The non-owning port's `rdata` is driven 0.
- `last` updates to the granted port on every grant.

## Timing
- Reset values: `a_gnt`=`b_gnt`=0 (gated by `rst`), `*_rvalid`=0, `*_rdata`=0, `mem_write_en`=1, `mem_address`=0, `mem_data_in`=0, owner=`OWN_NONE`, `last`=B, lock counter=0.
- Grant-to-data latency: 1 cycle (edge E issues the read, data valid from E until E+1).
- Back-to-back grants to alternating ports allowed every cycle; throughput 1 access/cycle.
- Write followed by read of the same address in consecutive cycles returns the new data.
- Requester must hold `req`, `we`, `addr`, `wdata` stable until it sees `gnt`=1 at a rising edge; dropping `req` earlier withdraws the request.
- Reset mid-operation: all state cleared immediately; a pending `rvalid` is discarded; no write is issued while `rst`=1.

## Configuration
- `DMEM_ARB_RR_EN` defined: on conflict in `OWN_NONE`, grant the port ≠ `last` (A first after reset).
- Undefined: fixed priority, A always wins conflicts; `last` is still maintained but unused. Lock behaviour unchanged in both builds.

## Test plan
- Single read: reset, then A reads addr 0x05 (memory holds 0x1234) → `a_gnt`=1 in cycle 0, `a_rvalid`=1 and `a_rdata`=0x1234 in cycle 1, `mem_write_en` stays 1.
- Conflict: A and B request reads of 0x01/0x02 continuously for 4 cycles → with `DMEM_ARB_RR_EN` grants A,B,A,B; without → A,A,A,A, `b_gnt` never 1.
- Write-then-read: B writes 0xBEEF to 0x10, then reads 0x10 → `mem_write_en`=0 for one cycle, then `b_rdata`=0xBEEF, `b_rvalid`=1.
- Lock: A reads 0x20 with lock, B requests throughout, A writes 0x20 and drops lock → B not granted until the cycle after A's write; then `b_gnt`=1.
- Forced release: A holds lock with `LOCK_MAX`=8 → after 8 cycles owner returns to `OWN_NONE` and B is granted.
- Reset mid-read: assert `rst` the cycle after A's grant → `a_rvalid`=0 immediately, `a_gnt`=0, `mem_write_en`=1.
